// File: rtl/cc_scheduler_if.sv
// rtl/cc_scheduler_if.sv - signal bundle between the CC scheduler and the TX path around it.
// The master side drives channel state, force and downstream ready; the slave side is the scheduler.
interface cc_scheduler_if #(
  parameter int CC_LENGTH = 3,
  parameter int CNT_W     = 16
);
  localparam int IDX_W = $clog2(CC_LENGTH + 1);

  logic             channel_up;
  logic             cc_force;
  logic             axi_ready_i;
  logic             axi_ready_o;
  logic             cc_insert;
  logic [IDX_W-1:0] cc_index;
  logic             cc_pending;
  logic [CNT_W-1:0] cc_bursts;

  modport master (
    output channel_up, cc_force, axi_ready_i,
    input  axi_ready_o, cc_insert, cc_index, cc_pending, cc_bursts
  );

  modport slave (
    input  channel_up, cc_force, axi_ready_i,
    output axi_ready_o, cc_insert, cc_index, cc_pending, cc_bursts
  );
endinterface

// File: rtl/cc_scheduler.sv
// rtl/cc_scheduler.sv - clock-compensation scheduler for the Aurora TX path.
// Stalls the AXI source and drives periodic or forced bursts of CC ordered sets.
module cc_scheduler #(
  parameter int CC_PERIOD = 5000,
  parameter int CC_LENGTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  cc_scheduler_if.slave  cc
);
  localparam int IDX_W  = $clog2(CC_LENGTH + 1);
  localparam int CNT_PW = $clog2(CC_PERIOD + 1);

  typedef enum logic [1:0] {S_DOWN, S_RUN, S_PREP, S_INSERT} state_t;

  state_t            r_state;
  logic [CNT_PW-1:0] r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_insert;
  logic              r_pending;
  logic [CNT_W-1:0]  r_bursts;

  logic w_periodic;
  logic w_forced;
  logic w_last_idx;

  // Count is anchored to the first INSERT cycle, so PREP entries land exactly CC_PERIOD apart.
  assign w_periodic = (r_cnt == CNT_PW'(CC_PERIOD - 2));
  assign w_forced   = cc.cc_force && (r_cnt != '0);
  assign w_last_idx = (r_idx == IDX_W'(CC_LENGTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_DOWN;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_insert  <= 1'b0;
      r_pending <= 1'b0;
      r_bursts  <= '0;
    end else if (!cc.channel_up) begin
      r_state   <= S_DOWN;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_insert  <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      case (r_state)
        S_DOWN: begin
          r_state <= S_RUN;
          r_cnt   <= CNT_PW'(1);
        end
        S_RUN: begin
          if (w_periodic || w_forced) begin
            r_state   <= S_PREP;
            r_pending <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_PW'(1);
          end
        end
        S_PREP: begin
          r_state   <= S_INSERT;
          r_pending <= 1'b0;
          r_insert  <= 1'b1;
          r_idx     <= '0;
          r_cnt     <= '0;
        end
        S_INSERT: begin
          r_cnt <= r_cnt + CNT_PW'(1);
          if (w_last_idx) begin
            r_state  <= S_RUN;
            r_insert <= 1'b0;
            r_idx    <= '0;
            if (r_bursts != '1) begin
              r_bursts <= r_bursts + CNT_W'(1);
            end
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
          r_state   <= S_DOWN;
          r_cnt     <= '0;
          r_idx     <= '0;
          r_insert  <= 1'b0;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  assign cc.axi_ready_o = cc.axi_ready_i && (r_state == S_RUN);
  assign cc.cc_insert   = r_insert;
  assign cc.cc_index    = r_idx;
  assign cc.cc_pending  = r_pending;
  assign cc.cc_bursts   = r_bursts;
endmodule

// File: tb/tb_cc_scheduler.sv
// tb/tb_cc_scheduler.sv - directed bench for cc_scheduler (period 16, burst length 3).
module tb_cc_scheduler;
  localparam int P = 16;
  localparam int L = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  cc_scheduler_if #(.CC_LENGTH(L), .CNT_W(16)) u_if ();
  cc_scheduler_if #(.CC_LENGTH(L), .CNT_W(2))  u_if_sat ();

  assign u_if_sat.channel_up  = u_if.channel_up;
  assign u_if_sat.cc_force    = u_if.cc_force;
  assign u_if_sat.axi_ready_i = u_if.axi_ready_i;

  cc_scheduler #(.CC_PERIOD(P), .CC_LENGTH(L), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cc(u_if)
  );

  cc_scheduler #(.CC_PERIOD(P), .CC_LENGTH(L), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cc(u_if_sat)
  );

  // {axi_ready_o, cc_pending, cc_insert, cc_index, cc_bursts}
  function automatic logic [20:0] obs();
    return {u_if.axi_ready_o, u_if.cc_pending, u_if.cc_insert, u_if.cc_index, u_if.cc_bursts};
  endfunction

  // Expected outputs at cycle c for periodic schedule with first PREP at cycle p.
  function automatic logic [20:0] sched(int c, int p, int base);
    int ph;
    int b;
    logic pend;
    logic ins;
    logic [1:0] idx;
    ph   = (c >= p) ? (c - p) % P : -1;
    pend = (ph == 0);
    ins  = (ph >= 1) && (ph <= L);
    idx  = ins ? 2'(ph - 1) : 2'd0;
    b    = (c >= p + L + 1) ? base + (c - p - L - 1) / P + 1 : base;
    return {~(pend | ins), pend, ins, idx, 16'(b)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    rst_n = 1'b0;
    u_if.channel_up  = 1'b0;
    u_if.cc_force    = 1'b0;
    u_if.axi_ready_i = 1'b1;
    tick();
    rst_n = 1'b1;
    u_if.channel_up = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_if.channel_up  = 1'b1;
    u_if.cc_force    = 1'b1;
    u_if.axi_ready_i = 1'b1;
    tick();
    total++;
    if (obs() !== 21'd0) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", obs(), 21'd0);
    end
    total++;
    if (u_if_sat.cc_bursts !== 2'd0) begin
      bad++;
      $display("FAIL reset_sat_bursts got=%0d want=0", u_if_sat.cc_bursts);
    end
    rst_n = 1'b1;
    u_if.cc_force = 1'b0;
    tick();
    total++;
    if (u_if.axi_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL run_ready got=%b want=1", u_if.axi_ready_o);
    end
    u_if.axi_ready_i = 1'b0;
    #1;
    total++;
    if (u_if.axi_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL ready_gated got=%b want=0", u_if.axi_ready_o);
    end
    u_if.axi_ready_i = 1'b1;
  endtask

  task automatic test_period();
    logic [20:0] e_v;
    start_run();
    for (int c = 1; c <= 51; c++) begin
      e_v = sched(c, 15, 0);
      total++;
      if (obs() !== e_v) begin
        bad++;
        $display("FAIL period c=%0d got=%h want=%h", c, obs(), e_v);
      end
      tick();
    end
  endtask

  task automatic test_forced();
    logic [20:0] e_v;
    start_run();
    for (int c = 1; c <= 26; c++) begin
      e_v = sched(c, 6, 0);
      total++;
      if (obs() !== e_v) begin
        bad++;
        $display("FAIL forced c=%0d got=%h want=%h", c, obs(), e_v);
      end
      u_if.cc_force = (c == 5);
      tick();
    end
    u_if.cc_force = 1'b0;
  endtask

  task automatic test_held_force();
    logic [20:0] e_v;
    int ph;
    int b;
    logic pend;
    logic ins;
    logic [1:0] idx;
    start_run();
    u_if.cc_force = 1'b1;
    for (int c = 1; c <= 41; c++) begin
      ph   = (c >= 2) ? (c - 2) % (L + 2) : -1;
      pend = (ph == 0);
      ins  = (ph >= 1) && (ph <= L);
      idx  = ins ? 2'(ph - 1) : 2'd0;
      b    = (c >= 6) ? (c - 6) / (L + 2) + 1 : 0;
      e_v  = {~(pend | ins), pend, ins, idx, 16'(b)};
      total++;
      if (obs() !== e_v) begin
        bad++;
        $display("FAIL held_force c=%0d got=%h want=%h", c, obs(), e_v);
      end
      if (c == 40) u_if.cc_force = 1'b0;
      tick();
    end
    for (int c = 42; c <= 60; c++) begin
      e_v = sched(c, 53, 8);
      total++;
      if (obs() !== e_v) begin
        bad++;
        $display("FAIL force_coincide c=%0d got=%h want=%h", c, obs(), e_v);
      end
      u_if.cc_force = (c == 52);
      tick();
    end
    u_if.cc_force = 1'b0;
  endtask

  task automatic test_channel_drop();
    logic [20:0] e_v;
    start_run();
    for (int c = 1; c <= 33; c++) begin
      e_v = sched(c, 15, 0);
      total++;
      if (obs() !== e_v) begin
        bad++;
        $display("FAIL drop_pre c=%0d got=%h want=%h", c, obs(), e_v);
      end
      if (c == 33) u_if.channel_up = 1'b0;
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      e_v = {1'b0, 1'b0, 1'b0, 2'd0, 16'd1};
      total++;
      if (obs() !== e_v) begin
        bad++;
        $display("FAIL drop_down k=%0d got=%h want=%h", k, obs(), e_v);
      end
      if (k == 1) u_if.channel_up = 1'b1;
      tick();
    end
    for (int c = 1; c <= 20; c++) begin
      e_v = sched(c, 15, 1);
      total++;
      if (obs() !== e_v) begin
        bad++;
        $display("FAIL drop_restart c=%0d got=%h want=%h", c, obs(), e_v);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [20:0] e_v;
    start_run();
    for (int c = 1; c <= 17; c++) begin
      e_v = sched(c, 15, 0);
      total++;
      if (obs() !== e_v) begin
        bad++;
        $display("FAIL rst_pre c=%0d got=%h want=%h", c, obs(), e_v);
      end
      if (c == 17) rst_n = 1'b0;
      tick();
    end
    total++;
    if (obs() !== 21'd0) begin
      bad++;
      $display("FAIL rst_mid got=%h want=%h", obs(), 21'd0);
    end
    rst_n = 1'b1;
    tick();
    for (int c = 1; c <= 19; c++) begin
      e_v = sched(c, 15, 0);
      total++;
      if (obs() !== e_v) begin
        bad++;
        $display("FAIL rst_restart c=%0d got=%h want=%h", c, obs(), e_v);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    logic [20:0] e_v;
    logic [1:0]  e_s;
    start_run();
    for (int c = 1; c <= 99; c++) begin
      e_v = sched(c, 15, 0);
      e_s = (e_v[15:0] > 16'd3) ? 2'd3 : e_v[1:0];
      total++;
      if (u_if_sat.cc_bursts !== e_s) begin
        bad++;
        $display("FAIL sat_bursts c=%0d got=%0d want=%0d", c, u_if_sat.cc_bursts, e_s);
      end
      total++;
      if (u_if.cc_bursts !== e_v[15:0]) begin
        bad++;
        $display("FAIL wide_bursts c=%0d got=%0d want=%0d", c, u_if.cc_bursts, e_v[15:0]);
      end
      tick();
    end
  endtask

  initial begin
    u_if.channel_up  = 1'b0;
    u_if.cc_force    = 1'b0;
    u_if.axi_ready_i = 1'b1;
    test_reset();
    test_period();
    test_forced();
    test_held_force();
    test_channel_drop();
    test_reset_mid_burst();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
